// File: rtl/rr_mux4to1_stream.sv
// rr_mux4to1_stream: four valid/ready input streams merged onto one
// registered output stream by fair round-robin, with a 2-bit source tag.
//
// Ports:
//   clk, rst    rising-edge clock, async active-high reset
//   in_valid    per-channel valid (bit i = channel i)
//   in_data     channel i data at in_data[i*DW +: DW]
//   in_last     per-channel end-of-packet
//   in_ready    per-channel ready, one-hot or zero
//   out_valid   registered output beat valid
//   out_data    registered output beat data
//   out_sel     source channel of the output beat
//   out_last    in_last of the accepted beat
//   out_ready   downstream ready
//
// Optional feature: define PKT_LOCK_EN to hold the grant on one channel
// from the first beat of a packet until its in_last beat, so packets are
// never interleaved. Without it, arbitration is beat-level round-robin.

module rr_mux4to1_stream #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  input  logic [3:0]      in_last,
  output logic [3:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_sel,
  output logic            out_last,
  input  logic            out_ready
);

  logic       load_ok;
  logic [1:0] last_grant;
  logic [3:0] req;
  logic [1:0] gnt;
  logic       gnt_any;
  logic [1:0] cand;
  logic       xfer;

`ifdef PKT_LOCK_EN
  typedef enum logic {
    ARB,
    LOCK
  } state_t;

  state_t     state;
  logic [1:0] lock_ch;

  // While locked, only the owning channel is eligible,
  // even if it is currently idle.
  always_comb begin
    req = in_valid;
    if (state == LOCK)
      req = in_valid & (4'b0001 << lock_ch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB;
      lock_ch <= 2'd0;
    end else if (xfer) begin
      unique case (state)
        ARB: begin
          if (!in_last[gnt]) begin
            state   <= LOCK;
            lock_ch <= gnt;
          end
        end
        LOCK: begin
          if (in_last[gnt])
            state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end
`else
  assign req = in_valid;
`endif

  assign load_ok = !out_valid || out_ready;

  // Scan from the channel after the last winner, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt     = 2'd0;
    cand    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = last_grant + 2'd1 + 2'(k);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt     = cand;
      end
    end
  end

  assign xfer = gnt_any && load_ok;

  assign in_ready = xfer ? (4'b0001 << gnt)
                         : 4'b0000;

  // Reload in the same cycle the register drains,
  // hold while stalled, clear valid on drain without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 2'd0;
      out_last   <= 1'b0;
      last_grant <= 2'd3;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[gnt*DW +: DW];
      out_sel    <= gnt;
      out_last   <= in_last[gnt];
      last_grant <= gnt;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux4to1_stream.sv
// tb_rr_mux4to1_stream: vector table, corner sequences and
// randomized run against a round-robin reference model.

module tb_rr_mux4to1_stream;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_last;
  logic        out_ready;

  int nchk;
  int nerr;

  rr_mux4to1_stream #(.DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int   m_lg;
  logic m_v;
  logic [7:0] m_d;
  int   m_s;
  logic m_l;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  sel;
    logic [7:0]  od;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lg = 3;
    m_v  = 1'b0;
    m_d  = 8'h00;
    m_s  = 0;
    m_l  = 1'b0;
  endtask

  // Returns the expected in_ready for the current inputs
  // and advances the model across the next clock edge.
  task automatic model_step(output logic [3:0] erdy);
    int  g;
    bit  lo;
    erdy = 4'b0000;
    g    = -1;
    lo   = !m_v || out_ready;
    for (int i = 1; i <= 4; i++) begin
      if (g < 0 && in_valid[(m_lg + i) % 4])
        g = (m_lg + i) % 4;
    end
    if (lo && g >= 0) begin
      erdy = 4'(1 << g);
      m_v  = 1'b1;
      m_d  = in_data[g*8 +: 8];
      m_s  = g;
      m_l  = in_last[g];
      m_lg = g;
    end else if (lo) begin
      m_v = 1'b0;
    end
  endtask

  task automatic apply(input logic [3:0] v,
                       input logic [31:0] d,
                       input logic [3:0] l,
                       input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid  = 4'b0;
    out_ready = 1'b0;
    edge_step();
    edge_step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_model();
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("out_data", 32'(out_data), 32'(m_d));
    chk("out_sel", 32'(out_sel), 32'(m_s));
    chk("out_last", 32'(out_last), 32'(m_l));
  endtask

  logic [3:0] erdy;
  int         seq[5];

  initial begin
    nchk = 0;
    nerr = 0;
    rst = 1'b1;
    in_valid = 4'b0;
    in_data = 32'b0;
    in_last = 4'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    do_reset();

    // Idle, single channel, all-valid RR, stall and drain
    for (int i = 0; i < 5; i++)
      tbl.push_back('{4'h0, 32'h0, 1'b1, 4'h0,
                      1'b0, 2'd0, 8'h00});
    tbl.push_back('{4'h4, 32'h00A50000, 1'b1, 4'h4,
                    1'b1, 2'd2, 8'hA5});
    tbl.push_back('{4'hF, 32'h13121110, 1'b1, 4'h8,
                    1'b1, 2'd3, 8'h13});
    tbl.push_back('{4'hF, 32'h13121110, 1'b1, 4'h1,
                    1'b1, 2'd0, 8'h10});
    tbl.push_back('{4'hF, 32'h13121110, 1'b1, 4'h2,
                    1'b1, 2'd1, 8'h11});
    tbl.push_back('{4'hF, 32'h13121110, 1'b1, 4'h4,
                    1'b1, 2'd2, 8'h12});
    tbl.push_back('{4'hF, 32'h13121110, 1'b1, 4'h8,
                    1'b1, 2'd3, 8'h13});
    tbl.push_back('{4'hF, 32'h13121110, 1'b1, 4'h1,
                    1'b1, 2'd0, 8'h10});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{4'hA, 32'h23002100, 1'b0, 4'h0,
                      1'b1, 2'd0, 8'h10});
    tbl.push_back('{4'hA, 32'h23002100, 1'b1, 4'h2,
                    1'b1, 2'd1, 8'h21});
    tbl.push_back('{4'hA, 32'h23002100, 1'b1, 4'h8,
                    1'b1, 2'd3, 8'h23});
    tbl.push_back('{4'hA, 32'h23002100, 1'b1, 4'h2,
                    1'b1, 2'd1, 8'h21});
    tbl.push_back('{4'h0, 32'h0, 1'b1, 4'h0,
                    1'b0, 2'd1, 8'h21});

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].d, 4'h0, tbl[i].ordy);
      chk($sformatf("tbl%0d_rdy", i),
          32'(in_ready), 32'(tbl[i].rdy));
      model_step(erdy);
      edge_step();
      chk($sformatf("tbl%0d_valid", i),
          32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_sel", i),
          32'(out_sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_data", i),
          32'(out_data), 32'(tbl[i].od));
    end

    // Reset while a beat is held in the output stage
    apply(4'h1, 32'h00000044, 4'h0, 1'b0);
    model_step(erdy);
    edge_step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    edge_step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      apply(4'hF, 32'h33323130, 4'h0, 1'b1);
      model_step(erdy);
      chk("post_rst_rdy", 32'(in_ready), 32'(erdy));
      edge_step();
      chk("post_rst_sel", 32'(out_sel), 32'(i));
      chk_model();
    end

    // ch0 three-beat packet with ch1 valid: beat-level RR
    do_reset();
    seq = '{0, 1, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      apply(4'h3, 32'h00005150, (i == 2) ? 4'h1 : 4'h0, 1'b1);
      model_step(erdy);
      edge_step();
      chk("pkt_sel", 32'(out_sel), 32'(seq[i]));
    end

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      apply(4'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
      model_step(erdy);
      chk("rnd_rdy", 32'(in_ready), 32'(erdy));
      edge_step();
      chk_model();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
